// File: rtl/mito_compute_core.sv
// mito_compute_core
//   Mode-switchable compute engine: multiply-accumulate (CONVOL / FULLY) or
//   max-pool over a configurable number of input beats per output, followed
//   by bias, optional ReLU, rounding right-shift, saturation and an output FIFO.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cfg_mode/relu/shift/passes  group configuration, latched on a group's first beat
//   in_valid/in_ready       input beat handshake
//   in_ifm/in_wgt           packed signed lanes, lane 0 in the LSBs
//   in_bias                 signed bias, used on the first beat of a group only
//   out_valid/out_ready     output handshake (show-ahead FIFO head)
//   out_data                signed result, 0 while the FIFO is empty
//   busy                    group open or its result not yet in the FIFO
//   err_mode                one-cycle pulse after a beat with cfg_mode=00
module mito_compute_core #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 9,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 8,
  parameter int POOL_LANES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              cfg_mode,
  input  logic                    cfg_relu,
  input  logic [4:0]              cfg_shift,
  input  logic [7:0]              cfg_passes,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_ifm,
  input  logic [LANES*DATA_W-1:0] in_wgt,
  input  logic [ACC_W-1:0]        in_bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    busy,
  output logic                    err_mode
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PEND_W = CNT_W + 1;

  localparam logic [1:0] MODE_INVALID = 2'b00;
  localparam logic [1:0] MODE_POOL    = 2'b11;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0]   OUT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   OUT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Lane unpacking
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] ifm_lane [LANES];
  logic signed [DATA_W-1:0] wgt_lane [LANES];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign ifm_lane[gi] = in_ifm[gi*DATA_W +: DATA_W];
      assign wgt_lane[gi] = in_wgt[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic signed [DATA_W-1:0] pool_max;
  always_comb begin
    pool_max = ifm_lane[0];
    for (int i = 1; i < POOL_LANES; i++) begin
      if (ifm_lane[i] > pool_max) pool_max = ifm_lane[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Group control: a group is open while the pass counter is non-zero. On the
  // first beat the live cfg_* inputs apply; afterwards the latched copies do.
  // ---------------------------------------------------------------------------
  logic [7:0] pass_cnt;
  logic [1:0] mode_reg;
  logic       relu_reg;
  logic [4:0] shift_reg;
  logic [7:0] passes_reg;

  logic       group_open;
  logic [1:0] eff_mode;
  logic       eff_relu;
  logic [4:0] eff_shift;
  logic [7:0] eff_passes;
  logic       accept, drop, beat, is_last;

  assign group_open = (pass_cnt != 8'd0);
  assign eff_mode   = group_open ? mode_reg  : cfg_mode;
  assign eff_relu   = group_open ? relu_reg  : cfg_relu;
  assign eff_shift  = group_open ? shift_reg : cfg_shift;
  assign eff_passes = group_open ? passes_reg : ((cfg_passes == 8'd0) ? 8'd1 : cfg_passes);
  assign accept     = in_valid && in_ready;
  // An invalid mode can only be latched on a first beat; such a beat is swallowed.
  assign drop       = accept && !group_open && (cfg_mode == MODE_INVALID);
  assign beat       = accept && !drop;
  assign is_last    = (pass_cnt == (eff_passes - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt   <= '0;
      mode_reg   <= '0;
      relu_reg   <= 1'b0;
      shift_reg  <= '0;
      passes_reg <= 8'd1;
      err_mode   <= 1'b0;
    end else begin
      err_mode <= drop;
      if (beat) begin
        if (!group_open) begin
          mode_reg   <= cfg_mode;
          relu_reg   <= cfg_relu;
          shift_reg  <= cfg_shift;
          passes_reg <= eff_passes;
        end
        pass_cnt <= is_last ? 8'd0 : (pass_cnt + 8'd1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: per-lane products (or pool max) plus the beat's control tags
  // ---------------------------------------------------------------------------
  logic                     s1_valid, s1_first, s1_last, s1_pool, s1_relu;
  logic [4:0]               s1_shift;
  logic signed [ACC_W-1:0]  s1_bias;
  logic signed [PROD_W-1:0] s1_prod [LANES];
  logic signed [DATA_W-1:0] s1_pmax;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_pool  <= 1'b0;
      s1_relu  <= 1'b0;
      s1_shift <= '0;
      s1_bias  <= '0;
      s1_pmax  <= '0;
      for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
    end else begin
      s1_valid <= beat;
      if (beat) begin
        s1_first <= !group_open;
        s1_last  <= is_last;
        s1_pool  <= (eff_mode == MODE_POOL);
        s1_relu  <= eff_relu;
        s1_shift <= eff_shift;
        s1_bias  <= in_bias;
        s1_pmax  <= pool_max;
        for (int i = 0; i < LANES; i++) s1_prod[i] <= ifm_lane[i] * wgt_lane[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: adder tree and saturating accumulator / running max
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] prod_sum, acc_base, acc_sat, pmax_ext, acc_next;
  logic signed [ACC_W:0]   sum_wide;

  always_comb begin
    prod_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_sum = prod_sum + {{(ACC_W-PROD_W){s1_prod[i][PROD_W-1]}}, s1_prod[i]};
    end
  end

  logic signed [ACC_W-1:0] acc_reg;
  logic                    s2_done, s2_relu;
  logic [4:0]              s2_shift;

  always_comb begin
    acc_base = s1_first ? s1_bias : acc_reg;
    sum_wide = {acc_base[ACC_W-1], acc_base} + {prod_sum[ACC_W-1], prod_sum};
    // Overflow shows up as disagreement between the two top bits.
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) acc_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else                                      acc_sat = sum_wide[ACC_W-1:0];
    pmax_ext = {{(ACC_W-DATA_W){s1_pmax[DATA_W-1]}}, s1_pmax};
    if (s1_pool) acc_next = (s1_first || (pmax_ext > acc_reg)) ? pmax_ext : acc_reg;
    else         acc_next = acc_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      s2_done  <= 1'b0;
      s2_relu  <= 1'b0;
      s2_shift <= '0;
    end else begin
      s2_done <= s1_valid && s1_last;
      if (s1_valid) begin
        acc_reg  <= acc_next;
        s2_relu  <= s1_relu;
        s2_shift <= s1_pool ? 5'd0 : s1_shift;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: ReLU, rounding shift, saturation to OUT_W. Computed one bit wider than
  // the accumulator so adding the rounding constant cannot overflow.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] post_v;
  logic signed [ACC_W:0]   post_w, rnd;
  logic [OUT_W-1:0]        post_out;
  logic                    s3_valid;
  logic [OUT_W-1:0]        s3_data;

  assign rnd = {{ACC_W{1'b0}}, 1'b1} << (s2_shift - 5'd1);

  always_comb begin
    post_v = acc_reg;
    if (s2_relu && acc_reg[ACC_W-1]) post_v = '0;
    post_w = {post_v[ACC_W-1], post_v};
    if (s2_shift != 5'd0) post_w = (post_w + rnd) >>> s2_shift;
    if (post_w > OUT_MAX)      post_out = OUT_MAX[OUT_W-1:0];
    else if (post_w < OUT_MIN) post_out = OUT_MIN[OUT_W-1:0];
    else                       post_out = post_w[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_data  <= '0;
    end else begin
      s3_valid <= s2_done;
      if (s2_done) s3_data <= post_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (show-ahead). in_ready reserves a slot for every result still
  // in the pipeline, so a push never finds the FIFO full without a pop.
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push, pop;
  logic [PEND_W-1:0] pending;

  assign push      = s3_valid;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s3_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign pending  = PEND_W'(fifo_count) + PEND_W'(s1_valid && s1_last)
                  + PEND_W'(s2_done) + PEND_W'(s3_valid);
  assign in_ready = (pending < PEND_W'(FIFO_DEPTH));
  assign busy     = group_open || (s1_valid && s1_last) || s2_done || s3_valid;

endmodule

// File: tb/tb_mito_compute_core.sv
// Directed testbench for mito_compute_core with hand-computed expectations.
module tb_mito_compute_core;

  localparam int DATA_W = 8;
  localparam int LANES  = 9;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 8;

  localparam logic [1:0] CONV  = 2'b01;
  localparam logic [1:0] FULLY = 2'b10;
  localparam logic [1:0] POOL  = 2'b11;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [1:0]               cfg_mode;
  logic                     cfg_relu;
  logic [4:0]               cfg_shift;
  logic [7:0]               cfg_passes;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*DATA_W-1:0]  in_ifm;
  logic [LANES*DATA_W-1:0]  in_wgt;
  logic [ACC_W-1:0]         in_bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     busy;
  logic                     err_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mito_compute_core dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_mode(cfg_mode), .cfg_relu(cfg_relu), .cfg_shift(cfg_shift), .cfg_passes(cfg_passes),
    .in_valid(in_valid), .in_ready(in_ready), .in_ifm(in_ifm), .in_wgt(in_wgt), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err_mode(err_mode)
  );

  task automatic set_cfg(input logic [1:0] m, input logic r, input logic [4:0] s, input logic [7:0] p);
    cfg_mode = m; cfg_relu = r; cfg_shift = s; cfg_passes = p;
  endtask

  task automatic fill(input int iv, input int wv);
    for (int i = 0; i < LANES; i++) begin
      in_ifm[i*DATA_W +: DATA_W] = DATA_W'(iv);
      in_wgt[i*DATA_W +: DATA_W] = DATA_W'(wv);
    end
  endtask

  task automatic set_pool(input int a, input int b, input int c, input int d);
    for (int i = 0; i < LANES; i++) begin
      in_ifm[i*DATA_W +: DATA_W] = DATA_W'(100);   // lanes beyond the pool window must be ignored
      in_wgt[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
    end
    in_ifm[0 +: DATA_W] = DATA_W'(a);
    in_ifm[DATA_W +: DATA_W] = DATA_W'(b);
    in_ifm[2*DATA_W +: DATA_W] = DATA_W'(c);
    in_ifm[3*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // Presents one beat; returns 1 ns after the edge that accepted it.
  task automatic send_beat();
    int  n;
    logic ok;
    in_valid = 1'b1; n = 0; ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); n++;
    end
    #1 in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout: in_ready stayed %0b, required 1", in_ready);
    end
  endtask

  // Counts edges until out_valid; sampled 1 ns after each edge.
  task automatic wait_out(output logic signed [OUT_W-1:0] d, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    d = out_data;
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL wait_out_timeout: out_valid=%0b, required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++; if (out_data !== 8'sd0) begin errors++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++; if (err_mode !== 1'b0) begin errors++; $display("FAIL reset_err_mode: got %0b required 0", err_mode); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_convol();
    logic signed [OUT_W-1:0] d; int lat;
    set_cfg(CONV, 1'b0, 5'd0, 8'd1); fill(1, 2); in_bias = 32'd3;
    send_beat();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL convol_busy: got %0b required 1", busy); end
    wait_out(d, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL convol_latency: got %0d required 3", lat); end
    checks++; if (d !== 21) begin errors++; $display("FAIL convol_data: got %0d required 21", d); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL convol_busy_end: got %0b required 0", busy); end
    idle(1);
    checks++; if (out_valid !== 1'b0 || out_data !== 8'sd0) begin errors++; $display("FAIL convol_empty: got valid=%0b data=%0d required 0/0", out_valid, out_data); end
    idle(1);
  endtask

  task automatic test_fully();
    logic signed [OUT_W-1:0] d; int lat;
    // shift 0, relu 0: 2 beats of 9*(-5) = -90; bias on beat 2 ignored
    set_cfg(FULLY, 1'b0, 5'd0, 8'd2); fill(-1, 5); in_bias = 32'd0;
    send_beat(); in_bias = 32'd10; send_beat();
    wait_out(d, lat);
    checks++; if (d !== -90) begin errors++; $display("FAIL fully_plain: got %0d required -90", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL fully_latency: got %0d required 3", lat); end
    idle(2);
    // shift 2: (-90+2)>>>2 = -22; cfg changes on beat 2 must be ignored
    set_cfg(FULLY, 1'b0, 5'd2, 8'd2); in_bias = 32'd0;
    send_beat(); set_cfg(2'b00, 1'b1, 5'd0, 8'd1); in_bias = 32'd10; send_beat();
    wait_out(d, lat);
    checks++; if (d !== -22) begin errors++; $display("FAIL fully_shift: got %0d required -22", d); end
    idle(2);
    // relu 1 clamps -90 to 0
    set_cfg(FULLY, 1'b1, 5'd0, 8'd2); in_bias = 32'd0;
    send_beat(); send_beat();
    wait_out(d, lat);
    checks++; if (d !== 0) begin errors++; $display("FAIL fully_relu: got %0d required 0", d); end
    idle(2);
  endtask

  task automatic test_saturation();
    logic signed [OUT_W-1:0] d; int lat;
    set_cfg(CONV, 1'b0, 5'd0, 8'd1); fill(127, 127); in_bias = 32'd0;
    send_beat(); wait_out(d, lat);
    checks++; if (d !== 127) begin errors++; $display("FAIL sat_pos: got %0d required 127", d); end
    idle(2);
    fill(-128, 127);
    send_beat(); wait_out(d, lat);
    checks++; if (d !== -128) begin errors++; $display("FAIL sat_neg: got %0d required -128", d); end
    idle(2);
    // 255 * 145161 = 37016055; rounded >>>20 gives 35
    set_cfg(CONV, 1'b0, 5'd20, 8'd255); fill(127, 127); in_bias = 32'd0;
    for (int i = 0; i < 255; i++) send_beat();
    wait_out(d, lat);
    checks++; if (d !== 35) begin errors++; $display("FAIL sat_255_passes: got %0d required 35", d); end
    idle(2);
    // bias at ACC max plus positive sums clamps at 2^31-1; rounded >>>31 gives 1 (a wrap would go negative)
    set_cfg(FULLY, 1'b0, 5'd31, 8'd2); in_bias = 32'h7FFF_FFFF;
    send_beat(); send_beat();
    wait_out(d, lat);
    checks++; if (d !== 1) begin errors++; $display("FAIL sat_acc_clamp: got %0d required 1", d); end
    idle(2);
  endtask

  task automatic test_pool();
    logic signed [OUT_W-1:0] d; int lat;
    set_cfg(POOL, 1'b0, 5'd3, 8'd2); in_bias = 32'd50;
    set_pool(-5, 7, 3, -2); send_beat();
    set_pool(4, 6, 9, 1);   send_beat();
    wait_out(d, lat);
    checks++; if (d !== 9) begin errors++; $display("FAIL pool_max: got %0d required 9", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL pool_latency: got %0d required 3", lat); end
    idle(2);
    set_cfg(POOL, 1'b0, 5'd3, 8'd2);
    set_pool(-5, -7, -3, -2); send_beat();
    set_pool(-9, -4, -8, -6); send_beat();
    wait_out(d, lat);
    checks++; if (d !== -2) begin errors++; $display("FAIL pool_negative: got %0d required -2", d); end
    idle(2);
    set_cfg(POOL, 1'b1, 5'd0, 8'd2);
    set_pool(-5, -7, -3, -2); send_beat();
    set_pool(-9, -4, -8, -6); send_beat();
    wait_out(d, lat);
    checks++; if (d !== 0) begin errors++; $display("FAIL pool_relu: got %0d required 0", d); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    longint t [3];
    int exp_v [3] = '{17, 34, 51};
    int idx, n, first_n, last_n;
    // passes=0 acts as a single pass; result k: 9*2*k - k = 17k
    set_cfg(CONV, 1'b0, 5'd0, 8'd0);
    for (int k = 0; k < 3; k++) begin
      fill(2, k + 1); in_bias = ACC_W'(-(k + 1));
      send_beat(); t[k] = $time;
    end
    checks++; if (t[1] - t[0] != 10 || t[2] - t[1] != 10) begin errors++; $display("FAIL b2b_accept_spacing: got %0d/%0d ns required 10/10", t[1]-t[0], t[2]-t[1]); end
    idx = 0; n = 0; first_n = 0; last_n = 0;
    while (idx < 3 && n < 20) begin
      @(negedge clk); n++;
      if (out_valid) begin
        if (idx == 0) first_n = n;
        last_n = n;
        checks++; if (out_data !== exp_v[idx]) begin errors++; $display("FAIL b2b_data%0d: got %0d required %0d", idx, out_data, exp_v[idx]); end
        idx++;
      end
    end
    checks++; if (idx != 3 || last_n - first_n != 2) begin errors++; $display("FAIL b2b_stream: got %0d results over %0d cycles required 3 over 2", idx, last_n - first_n); end
    idle(2);
  endtask

  task automatic test_backpressure();
    int exp_v [6] = '{9, 19, 29, 39, 49, 59};
    int idx, n;
    out_ready = 1'b0;
    set_cfg(CONV, 1'b0, 5'd0, 8'd1);
    for (int k = 0; k < 4; k++) begin
      fill(1, k + 1); in_bias = ACC_W'(k);
      send_beat();
      if (k == 2) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_at3: got %0b required 1", in_ready); end
      end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_at4: got %0b required 0", in_ready); end
    idle(5);
    checks++; if (out_valid !== 1'b1 || out_data !== 9) begin errors++; $display("FAIL bp_head: got valid=%0b data=%0d required 1/9", out_valid, out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %0b required 0", in_ready); end
    idle(2);
    checks++; if (out_data !== 9) begin errors++; $display("FAIL bp_head_stable: got %0d required 9", out_data); end
    idx = 0; n = 0;
    fork
      begin
        fill(1, 5); in_bias = 32'd4; send_beat();
        fill(1, 6); in_bias = 32'd5; send_beat();
      end
      begin
        out_ready = 1'b1;
        while (idx < 6 && n < 80) begin
          @(negedge clk); n++;
          if (out_valid) begin
            checks++; if (out_data !== exp_v[idx]) begin errors++; $display("FAIL bp_order%0d: got %0d required %0d", idx, out_data, exp_v[idx]); end
            idx++;
          end
        end
      end
    join
    checks++; if (idx != 6) begin errors++; $display("FAIL bp_count: got %0d results required 6", idx); end
    idle(2);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain: got valid=%0b ready=%0b required 0/1", out_valid, in_ready); end
  endtask

  task automatic test_err_mode();
    set_cfg(2'b00, 1'b0, 5'd0, 8'd1); fill(3, 3); in_bias = 32'd0;
    send_beat();
    checks++; if (err_mode !== 1'b1) begin errors++; $display("FAIL err_pulse: got %0b required 1", err_mode); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy: got %0b required 0", busy); end
    idle(1);
    checks++; if (err_mode !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %0b required 0", err_mode); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_no_output: got %0b required 0", out_valid); end
      idle(1);
    end
  endtask

  task automatic test_reset_mid_group();
    logic signed [OUT_W-1:0] d; int lat;
    out_ready = 1'b0;
    set_cfg(CONV, 1'b0, 5'd0, 8'd1); fill(1, 2); in_bias = 32'd3;
    send_beat(); idle(4);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_fifo: got %0b required 1", out_valid); end
    set_cfg(CONV, 1'b0, 5'd0, 8'd3); send_beat();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %0b required 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'sd0) begin errors++; $display("FAIL rst_mid_out: got valid=%0b data=%0d required 0/0", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got ready=%0b busy=%0b required 1/0", in_ready, busy); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    idle(1);
    // fresh group: 9*3*(-2) + 5 = -49
    set_cfg(CONV, 1'b0, 5'd0, 8'd1); fill(3, -2); in_bias = 32'd5;
    send_beat(); wait_out(d, lat);
    checks++; if (d !== -49 || lat !== 3) begin errors++; $display("FAIL rst_after: got %0d lat %0d required -49 lat 3", d, lat); end
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_cfg(CONV, 1'b0, 5'd0, 8'd1); fill(0, 0); in_bias = '0;
    test_reset();
    test_convol();
    test_fully();
    test_saturation();
    test_pool();
    test_back_to_back();
    test_backpressure();
    test_err_mode();
    test_reset_mid_group();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mito_compute_core.md
Name: mito_compute_core

Overview:
- Parametrised successor to the accelerator's compute datapath (PE array, ReLU, max-pool and OFM buffer).
- Merges them into one mode-switchable engine with valid/ready handshakes on both sides.
- Accumulates a configurable number of input beats per output, which gives channel/depth accumulation. Adds bias, optional ReLU, rounding right-shift requantisation, saturation, and an output FIFO.
- Sits between the main buffer (ifm/wgt/bias vectors) and the OFM store.

Parameters:
- DATA_W, 8, signed ifm/wgt element width
- LANES, 9, elements per beat (PE array size)
- ACC_W, 32, signed accumulator and bias width
- OUT_W, 8, signed output width
- POOL_LANES, 4, lanes 0..POOL_LANES-1 used in pool mode (≤ LANES)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_mode  in  2  01 CONVOL, 10 FULLY, 11 POOL, 00 invalid
- cfg_relu  in  1  enable ReLU
- cfg_shift  in  5  arithmetic right-shift amount
- cfg_passes  in  8  beats per output; 0 treated as 1
- in_valid  in  1  input beat valid
- in_ready  out  1  core can accept beat
- in_ifm  in  LANES*DATA_W  packed signed ifm, lane 0 in LSBs
- in_wgt  in  LANES*DATA_W  packed signed weights
- in_bias  in  ACC_W  signed bias, sampled on first beat of a group only
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  OUT_W  signed result
- busy  out  1  group open or result in flight
- err_mode  out  1  one-cycle pulse on beat with cfg_mode=00

Behaviour:
- Reset (async, rst_n=0): accumulator, pass counter, pipeline valids, FIFO pointers and count cleared. Output reset values: out_valid=0, out_data=0, busy=0, err_mode=0, in_ready=1. Reset mid-group discards the partial sum and all FIFO contents.
- Beat accepted when in_valid && in_ready. The cfg_* fields are latched on the first beat of a group and held until the group's last beat. Changes mid-group are ignored.
- Mode 00: the beat is accepted and dropped, and err_mode pulses in the next cycle. The group state is not opened.
- Pipeline:
  - S1 (T+1): LANES signed products registered.
  - S2 (T+2): adder tree sum (sign-extended to ACC_W). On the first beat the accumulator is loaded with bias+sum; on later beats it adds sum. The accumulator saturates at signed ACC_W bounds.
  - S3: on the last beat, the post stage writes the FIFO.
- Latency: last beat accepted at edge T gives out_valid=1 at cycle T+3 when the FIFO was empty. Back-to-back beats are accepted at one per cycle.
- POOL mode:
  - S1 takes the max over lanes 0..POOL_LANES-1 of in_ifm; in_wgt and in_bias are ignored.
  - S2 loads the per-beat max on the first beat, then keeps the running max.
  - Post stage uses shift 0.
- Post stage, in order:
  - ReLU (if enabled, negative → 0).
  - If shift s>0: v = (v + 2^(s-1)) >>> s.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Pass counter counts 0..passes-1 and wraps to 0 at group end. The next beat starts a new group, with no idle cycle.
- FIFO:
  - Show-ahead; out_data is held stable while out_valid && !out_ready.
  - Simultaneous push and pop is legal at any occupancy, including full.
  - Order is preserved.
  - out_data returns to 0 when the FIFO is empty.
- in_ready = (fifo_count + results_in_flight_S1..S3) < FIFO_DEPTH. It is registered/combinational from state only and never depends on in_valid. No result is ever dropped.
- busy=1 from the first accepted beat of a group until its result enters the FIFO.

Test Plan:
1. CONVOL, passes=1, shift=0, relu=0, ifm all 1, wgt all 2, bias=3 → out_data=21, out_valid rises exactly 3 cycles after the accepting edge.
2. FULLY, passes=2, ifm all -1, wgt all 5, bias=0 → relu=0, shift=0: -90 saturates to -90. With shift=2 → -22. With relu=1 → 0. Bias is applied once only: bias=10 on beat 2 is ignored.
3. Saturation: ifm all 127, wgt all 127 → 127. ifm all -128, wgt all 127 → -128. Accumulator does not wrap over 255 passes of maximum product.
4. POOL, passes=2, POOL_LANES=4: beat 1 lanes {-5,7,3,-2}, beat 2 lanes {4,6,9,1}, wgt random → 9. All-negative lanes with relu=1 → 0.
5. Backpressure: out_ready=0, stream 6 single-pass groups → in_ready drops once 4 results are pending. Release out_ready → all 6 results emerge in order, none lost. Simultaneous push/pop at full is exercised.
6. cfg_mode=00 beat → err_mode one-cycle pulse, no output. Assert rst_n mid-group with FIFO non-empty → out_valid=0, in_ready=1 immediately. The next group computes correctly.
